// File: rtl/swhw_pkg.sv
// Shared types and constants for the session/stream hardware blocks:
// message-type encoding, lane indices and AXI-Stream widths.
package swhw_pkg;

  typedef enum logic [7:0] {
    SWHW_MSG_TYPE_NONE                 = 8'd0,
    SWHW_MSG_TYPE_SESSION_REGISTRATION = 8'd1,
    SWHW_MSG_TYPE_VENUE_BOUND_WRAPPED  = 8'd2
  } swhw_msg_type_enum_t;

  localparam int LANE_0 = 0;
  localparam int LANE_1 = 1;
  localparam int LANE_2 = 2;
  localparam int LANE_3 = 3;
  localparam int LANE_4 = 4;
  localparam int LANE_5 = 5;
  localparam int LANE_6 = 6;
  localparam int LANE_7 = 7;

  localparam int DATA_W = 32;
  localparam int KEEP_W = 4;

endpackage

// File: rtl/axis_lane_arbiter_rr_pick.sv
// Combinational round-robin first-one search. Priority requests, when any are
// present, are searched instead of the plain request vector.
module rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [N-1:0]     prio_i,
  input  logic [IDX_W-1:0] start_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o
);

  logic [N-1:0] eff;
  logic [N-1:0] rot;
  int           offs;

  always_comb begin
    eff     = ((req_i & prio_i) != '0) ? (req_i & prio_i) : req_i;
    // rot[0] is the lane at start_i, rot[1] the next one up, and so on
    rot     = N'({eff, eff} >> start_i);
    found_o = 1'b0;
    offs    = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found_o = 1'b1;
        offs    = i;
      end
    end
    idx_o = IDX_W'((int'(start_i) + offs) % N);
  end

endmodule

// File: rtl/axis_lane_arbiter.sv
// Frame-atomic N:1 AXI-Stream lane arbiter, round-robin between frames.
// Define ARB_PRIORITY_EN to let session-registration first beats jump the queue.
module axis_lane_arbiter
  import swhw_pkg::*;
#(
  parameter int NUM_LANES = 2,
  parameter int CNT_W     = 16
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic                         s_axis_tvalid [NUM_LANES],
  input  logic [DATA_W-1:0]            s_axis_tdata  [NUM_LANES],
  input  logic [KEEP_W-1:0]            s_axis_tkeep  [NUM_LANES],
  input  logic                         s_axis_tlast  [NUM_LANES],
  output logic                         s_axis_tready [NUM_LANES],
  output logic                         m_axis_tvalid,
  output logic [DATA_W-1:0]            m_axis_tdata,
  output logic [KEEP_W-1:0]            m_axis_tkeep,
  output logic                         m_axis_tlast,
  input  logic                         m_axis_tready,
  output logic [$clog2(NUM_LANES)-1:0] grant_lane,
  output logic                         busy,
  output logic [CNT_W-1:0]             frame_count
);

  // state | meaning
  // ARB   | no frame owns the output; all readies low, choosing the next lane
  // PASS  | granted lane streams straight through until its tlast is accepted
  typedef enum logic {ARB, PASS} state_e;

  localparam int IDX_W = $clog2(NUM_LANES);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [NUM_LANES-1:0] req, prio;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_found;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign req[g] = s_axis_tvalid[g];
`ifdef ARB_PRIORITY_EN
    // first-beat data is stable while valid is held, so peeking it here is safe
    assign prio[g] = (s_axis_tdata[g][7:0] == 8'(SWHW_MSG_TYPE_SESSION_REGISTRATION));
`else
    assign prio[g] = 1'b0;
`endif
  end

  rr_pick #(
    .N     (NUM_LANES),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req_i   (req),
    .prio_i  (prio),
    .start_i (rr_ptr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_ptr_d      = rr_ptr_q;
    count_d       = count_q;
    busy          = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = s_axis_tdata[grant_q];
    m_axis_tkeep  = s_axis_tkeep[grant_q];
    m_axis_tlast  = s_axis_tlast[grant_q];
    for (int i = 0; i < NUM_LANES; i++) s_axis_tready[i] = 1'b0;

    case (state_q)
      ARB: begin
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = PASS;
        end
      end
      PASS: begin
        busy                   = 1'b1;
        m_axis_tvalid          = s_axis_tvalid[grant_q];
        s_axis_tready[grant_q] = m_axis_tready;
        if (s_axis_tvalid[grant_q] && m_axis_tready && s_axis_tlast[grant_q]) begin
          state_d  = ARB;
          rr_ptr_d = (grant_q == IDX_W'(NUM_LANES - 1)) ? '0 : grant_q + 1'b1;
          count_d  = count_q + 1'b1;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= ARB;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign grant_lane  = grant_q;
  assign frame_count = count_q;

endmodule

// File: tb/tb_axis_lane_arbiter.sv
// Scoreboard bench for axis_lane_arbiter: lane drivers feed frame queues, a
// frame-level arbitration model predicts output order, a monitor checks it.
module tb_axis_lane_arbiter;

  localparam int NL = 3;
  localparam int CW = 4;
`ifdef ARB_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  typedef struct packed {
    logic [7:0]  lane;
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  typedef struct packed {
    logic [2:0]       len;
    logic [3:0][31:0] d;
    logic [3:0][3:0]  k;
  } frm_t;

  logic          aclk;
  logic          aresetn;
  logic          s_axis_tvalid [NL];
  logic [31:0]   s_axis_tdata  [NL];
  logic [3:0]    s_axis_tkeep  [NL];
  logic          s_axis_tlast  [NL];
  logic          s_axis_tready [NL];
  logic          m_axis_tvalid;
  logic [31:0]   m_axis_tdata;
  logic [3:0]    m_axis_tkeep;
  logic          m_axis_tlast;
  logic          m_axis_tready;
  logic [1:0]    grant_lane;
  logic          busy;
  logic [CW-1:0] frame_count;

  axis_lane_arbiter #(.NUM_LANES(NL), .CNT_W(CW)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .grant_lane    (grant_lane),
    .busy          (busy),
    .frame_count   (frame_count)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    busy_cnt = 0;
  int    m_rr = 0;
  int    m_count = 0;
  bit    rdy_rand = 1'b0;
  bit    mon_en = 1'b0;
  beat_t lane_q [NL][$];
  beat_t exp_q [$];
  frm_t  stage [NL][$];
  int    acc_cyc [$];
  int    grant_log [$];
  int    want [$];
  bit    rdy_pat [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // lane sources: hold each beat until accepted, junk data while idle
  initial begin
    for (int l = 0; l < NL; l++) begin
      s_axis_tvalid[l] = 1'b0;
      s_axis_tdata[l]  = '0;
      s_axis_tkeep[l]  = '0;
      s_axis_tlast[l]  = 1'b0;
    end
    m_axis_tready = 1'b1;
    forever begin
      @(negedge aclk);
      cyc++;
      for (int l = 0; l < NL; l++) begin
        if (lane_q[l].size() > 0) begin
          s_axis_tvalid[l] = 1'b1;
          s_axis_tdata[l]  = lane_q[l][0].data;
          s_axis_tkeep[l]  = lane_q[l][0].keep;
          s_axis_tlast[l]  = lane_q[l][0].last;
        end else begin
          s_axis_tvalid[l] = 1'b0;
          s_axis_tdata[l]  = $urandom();
          s_axis_tkeep[l]  = 4'($urandom());
          s_axis_tlast[l]  = 1'($urandom());
        end
      end
      if (rdy_pat.size() > 0) m_axis_tready = rdy_pat.pop_front();
      else if (rdy_rand)      m_axis_tready = 1'($urandom_range(0, 1));
      else                    m_axis_tready = 1'b1;
      #3;
      for (int l = 0; l < NL; l++)
        if (s_axis_tvalid[l] && s_axis_tready[l] && lane_q[l].size() > 0)
          void'(lane_q[l].pop_front());
    end
  end

  // monitor: compare every presented output beat against the scoreboard head
  initial begin
    beat_t e;
    forever begin
      @(negedge aclk);
      #3;
      if (mon_en && aresetn) begin
        if (busy) busy_cnt++;
        if (m_axis_tvalid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat actual=%0h required=none", m_axis_tdata);
          end else begin
            e = exp_q[0];
            chk("grant_lane", grant_lane, e.lane);
            chk("m_tdata", m_axis_tdata, e.data);
            chk("m_tkeep", m_axis_tkeep, e.keep);
            chk("m_tlast", m_axis_tlast, e.last);
            for (int l = 0; l < NL; l++)
              chk("s_tready_pass", s_axis_tready[l], (l == int'(e.lane)) ? m_axis_tready : 1'b0);
            if (m_axis_tready) begin
              void'(exp_q.pop_front());
              acc_cyc.push_back(cyc);
              if (e.last) grant_log.push_back(int'(grant_lane));
            end
          end
        end else begin
          for (int l = 0; l < NL; l++) chk("s_tready_idle", s_axis_tready[l], 1'b0);
        end
      end
    end
  end

  function automatic frm_t mk(input int len, input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] d2, input logic [31:0] d3);
    frm_t f;
    f.len = 3'(len);
    f.d   = {d3, d2, d1, d0};
    f.k   = {4'hF, 4'hF, 4'hF, 4'hF};
    return f;
  endfunction

  function automatic frm_t rand_frame();
    frm_t f;
    f.len = 3'($urandom_range(1, 4));
    for (int b = 0; b < 4; b++) begin
      f.d[b] = $urandom();
      f.k[b] = 4'($urandom_range(1, 15));
    end
    case ($urandom_range(0, 3))
      0:       f.d[0][7:0] = 8'h00;
      1:       f.d[0][7:0] = 8'h01;
      2:       f.d[0][7:0] = 8'h02;
      default: f.d[0][7:0] = f.d[0][7:0];
    endcase
    return f;
  endfunction

  // hand staged frames to the sources and predict the granted frame order
  task automatic commit();
    bit    any, pr;
    int    w;
    beat_t bt;
    for (int l = 0; l < NL; l++)
      for (int f = 0; f < stage[l].size(); f++)
        for (int b = 0; b < int'(stage[l][f].len); b++) begin
          bt.lane = 8'(l);
          bt.data = stage[l][f].d[b];
          bt.keep = stage[l][f].k[b];
          bt.last = (b == int'(stage[l][f].len) - 1);
          lane_q[l].push_back(bt);
        end
    for (int n = 0; n < 64; n++) begin
      any = 1'b0;
      pr  = 1'b0;
      for (int l = 0; l < NL; l++)
        if (stage[l].size() > 0) begin
          any = 1'b1;
          if (PRIO && stage[l][0].d[0][7:0] == 8'h01) pr = 1'b1;
        end
      if (!any) break;
      w = -1;
      for (int o = 0; o < NL; o++) begin
        int l;
        l = (m_rr + o) % NL;
        if (w < 0 && stage[l].size() > 0 && (!pr || stage[l][0].d[0][7:0] == 8'h01)) w = l;
      end
      for (int b = 0; b < int'(stage[w][0].len); b++) begin
        bt.lane = 8'(w);
        bt.data = stage[w][0].d[b];
        bt.keep = stage[w][0].k[b];
        bt.last = (b == int'(stage[w][0].len) - 1);
        exp_q.push_back(bt);
      end
      void'(stage[w].pop_front());
      m_rr = (w + 1) % NL;
      m_count++;
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(posedge aclk);
      #1;
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
    repeat (2) @(posedge aclk);
    #1;
  endtask

  task automatic reset_and_check();
    aresetn = 1'b0;
    for (int l = 0; l < NL; l++) begin
      lane_q[l].delete();
      stage[l].delete();
    end
    exp_q.delete();
    rdy_pat.delete();
    m_rr    = 0;
    m_count = 0;
    #1;
    chk("rst_m_tvalid", m_axis_tvalid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_grant_lane", grant_lane, 0);
    for (int l = 0; l < NL; l++) chk("rst_s_tready", s_axis_tready[l], 1'b0);
    @(negedge aclk);
    #2;
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge aclk);
    #1;
    reset_and_check();
  endtask

  task automatic chk_cycles(input string nm, input int start);
    chk({nm, "_count"}, acc_cyc.size(), want.size());
    for (int i = 0; i < want.size() && i < acc_cyc.size(); i++)
      chk(nm, acc_cyc[i], start + want[i]);
  endtask

  task automatic chk_grants(input string nm);
    chk({nm, "_count"}, grant_log.size(), want.size());
    for (int i = 0; i < want.size() && i < grant_log.size(); i++)
      chk(nm, grant_log[i], want[i]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  start;
    bit  hit;
    aresetn = 1'b1;
    @(posedge aclk);
    do_reset();
    mon_en = 1'b1;

    // single lane, 3 beats: beats one cycle after tvalid, back to back
    acc_cyc.delete();
    busy_cnt = 0;
    start = cyc + 1;
    stage[0].push_back(mk(3, 32'h11, 32'h22, 32'h33, 32'h0));
    commit();
    drain(50);
    want = '{1, 2, 3};
    chk_cycles("single_beat_cycle", start);
    chk("single_busy_cycles", busy_cnt, 3);
    chk("single_frame_count", frame_count, 1);

    // contention from reset: lane 0 then lane 1 with one bubble
    do_reset();
    acc_cyc.delete();
    grant_log.delete();
    start = cyc + 1;
    stage[0].push_back(mk(2, 32'hA000, 32'hA001, 32'h0, 32'h0));
    stage[1].push_back(mk(2, 32'hB000, 32'hB001, 32'h0, 32'h0));
    commit();
    drain(50);
    want = '{1, 2, 4, 5};
    chk_cycles("contend_beat_cycle", start);
    want = '{0, 1};
    chk_grants("contend_grant");
    chk("contend_frame_count", frame_count, 2);

    // backpressure 1,0,1,0.. on a 4-beat frame
    acc_cyc.delete();
    start = cyc + 1;
    rdy_pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    stage[1].push_back(mk(4, 32'hC0, 32'hC1, 32'hC2, 32'hC3));
    commit();
    drain(50);
    want = '{1, 3, 5, 7};
    chk_cycles("bp_beat_cycle", start);

    // fairness: two lanes streaming 3 frames each
    grant_log.delete();
    for (int f = 0; f < 3; f++) begin
      stage[0].push_back(mk(2, 32'hD0 + f, 32'hD8, 32'h0, 32'h0));
      stage[1].push_back(mk(3, 32'hE0 + f, 32'hE8, 32'hE9, 32'h0));
    end
    commit();
    drain(200);
    want = '{0, 1, 0, 1, 0, 1};
    chk_grants("fair_grant");

    // priority: rr_ptr at 1, lane 1 holds 0x02, lane 0 holds 0x01
    stage[0].push_back(mk(1, 32'h05, 32'h0, 32'h0, 32'h0));
    commit();
    drain(50);
    grant_log.delete();
    stage[1].push_back(mk(2, 32'h02, 32'h0F0, 32'h0, 32'h0));
    stage[0].push_back(mk(2, 32'h01, 32'h0F1, 32'h0, 32'h0));
    commit();
    drain(50);
    chk("prio_frames", grant_log.size(), 2);
    if (grant_log.size() > 0) chk("prio_first_grant", grant_log[0], PRIO ? 0 : 1);

    // reset while beat 2 of 4 is on the output
    stage[2].push_back(mk(4, 32'hA0, 32'hA1, 32'hA2, 32'hA3));
    commit();
    hit = 1'b0;
    for (int n = 0; n < 20 && !hit; n++) begin
      @(negedge aclk);
      #1;
      if (m_axis_tvalid && m_axis_tdata == 32'hA1) hit = 1'b1;
    end
    chk("midrst_beat2_seen", hit, 1'b1);
    reset_and_check();
    grant_log.delete();
    stage[1].push_back(mk(2, 32'h77, 32'h78, 32'h0, 32'h0));
    commit();
    drain(50);
    chk("midrst_after_count", frame_count, 1);
    chk("midrst_after_grant", grant_lane, 1);

    // randomized rounds, random backpressure, frame_count wraps at 16
    for (int r = 0; r < 30; r++) begin
      rdy_rand = 1'($urandom_range(0, 1));
      for (int l = 0; l < NL; l++) begin
        int nf;
        nf = $urandom_range(0, 2);
        for (int f = 0; f < nf; f++) stage[l].push_back(rand_frame());
      end
      commit();
      drain(400);
      chk("rand_frame_count", frame_count, 32'(m_count % 16));
    end
    rdy_rand = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_lane_arbiter.md
# axis_lane_arbiter

Frame-atomic N:1 AXI-Stream arbiter that merges several 32-bit ingress lanes into the single stream feeding the async CDC FIFO and the egress mux. It sits upstream of the FIFO in the controller clock domain and replaces hard-wiring one lane to the datapath. A frame, once granted, owns the output until its `tlast` beat is accepted. Selection is round-robin, with an optional priority override for session-registration messages.

## Interface
- `NUM_LANES`, default 2 — number of ingress lanes, 2..8.
- `CNT_W`, default 16 — width of the forwarded-frame counter.
- `aclk`  in  1  — single clock for all ports.
- `aresetn`  in  1  — asynchronous, active-low reset.
- `s_axis_tvalid`  in  [NUM_LANES]  — per-lane valid (unpacked array).
- `s_axis_tdata`  in  [NUM_LANES] x 32  — per-lane data.
- `s_axis_tkeep`  in  [NUM_LANES] x 4  — per-lane byte enables.
- `s_axis_tlast`  in  [NUM_LANES]  — per-lane end of frame.
- `s_axis_tready`  out  [NUM_LANES]  — per-lane ready.
- `m_axis_tvalid` / `m_axis_tdata` [32] / `m_axis_tkeep` [4] / `m_axis_tlast`  out — merged stream.
- `m_axis_tready`  in  1  — downstream ready (FIFO write side).
- `grant_lane`  out  $clog2(NUM_LANES)  — currently or last granted lane.
- `busy`  out  1  — high while a frame is in flight.
- `frame_count`  out  CNT_W  — frames completed; wraps modulo 2^CNT_W.

## Operation
- The FSM has two states, ARB and PASS.
- **ARB**
  - All `s_axis_tready` are 0 and `m_axis_tvalid` is 0.
  - If any `s_axis_tvalid` is set, pick a winner and register it in `grant_lane`, then go to PASS next cycle.
  - Round-robin search starts at `rr_ptr` and scans upward, wrapping at NUM_LANES.
- **PASS**
  - `m_axis_*` is driven combinationally from lane `grant_lane`.
  - `s_axis_tready[grant_lane]` = `m_axis_tready`; all other readies are 0.
  - On a beat with `m_axis_tvalid & m_axis_tready & m_axis_tlast`:
    - go to ARB;
    - set `rr_ptr` = `grant_lane`+1 (mod NUM_LANES);
    - increment `frame_count`.
- An input lane never sees `tready` while not granted, so no beats are lost or interleaved.
- `busy` = (state == PASS).
- A single-beat frame (`tlast` on the first beat) is legal and completes in one PASS cycle.

## Timing
- Reset values:
  - state ARB, `rr_ptr` 0, `grant_lane` 0, `frame_count` 0, `busy` 0;
  - all `s_axis_tready` 0, `m_axis_tvalid` 0;
  - `m_axis_tdata`, `m_axis_tkeep` and `m_axis_tlast` are don't-care while `m_axis_tvalid` is 0.
- Arbitration latency: the first beat appears on `m_axis` one cycle after `tvalid` is seen in ARB.
- There is exactly one ARB bubble cycle between back-to-back frames.
- Throughput inside a frame is 1 beat/cycle when `m_axis_tready` is held high.
- Output backpressure passes straight through to the granted lane, with zero added latency.
- Inputs must obey AXIS rules: `tvalid` never drops and `tdata` is stable until accepted. The block relies on this when peeking first-beat data in ARB.
- Deasserting `aresetn` mid-frame returns everything to the reset values immediately, and the in-flight frame is truncated.
  - Upstream sources are reset by the same signal.
- `frame_count` wraps from all-ones to 0 silently.

## Configuration
- `ARB_PRIORITY_EN` defined:
  - In ARB, any valid lane whose first beat has `tdata[7:0]` == `SWHW_MSG_TYPE_SESSION_REGISTRATION` wins over round-robin order.
  - Among several such lanes, the round-robin order from `rr_ptr` decides.
  - `rr_ptr` still updates from the actual winner.
- `ARB_PRIORITY_EN` undefined: pure round-robin, and `tdata` is not inspected in ARB.

## Structure
- Shared package `swhw_pkg` holds:
  - `swhw_msg_type_enum_t` (NONE=0, SESSION_REGISTRATION=1, VENUE_BOUND_WRAPPED=2);
  - the `LANE_*` index constants;
  - AXIS width constants (DATA_W=32, KEEP_W=4).
- One sub-module, `rr_pick`: combinational round-robin first-one search that takes a request vector, a start pointer and an optional priority mask, and returns the index plus a found flag.
- The FSM, mux and counter stay in the top module.

## Test plan
- Single lane: lane 0 sends a 3-beat frame (0x11,0x22,0x33, `tlast` on beat 3, `tkeep` 0xF), `m_axis_tready`=1.
  - Expect beats on `m_axis` in cycles 1..3 after `tvalid`; `frame_count`=1; `busy` high for 3 cycles.
- Contention: lanes 0 and 1 both hold 2-beat frames from reset.
  - Expect lane 0 then lane 1, with no interleaving and one idle cycle between; `grant_lane` 0 then 1; `frame_count`=2.
- Backpressure: toggle `m_axis_tready` 1,0,1,0 during a 4-beat frame.
  - Expect `s_axis_tready` of the granted lane to mirror it, `m_axis_tdata` to hold stable while stalled, and all 4 beats delivered in order.
- Fairness: both lanes stream continuously for 6 frames.
  - Expect alternating grants 0,1,0,1,0,1.
- With `ARB_PRIORITY_EN` defined, after a lane 0 frame makes `rr_ptr`=1: lane 1 presents first-beat 0x02 and lane 0 presents 0x01.
  - Expect lane 0 granted; without the macro, expect lane 1.
- Reset mid-frame: drop `aresetn` on beat 2 of 4.
  - Expect the same cycle: `m_axis_tvalid`=0, `s_axis_tready`=0, `frame_count`=0, `grant_lane`=0; a new frame after release arbitrates normally.
